// File: rtl/lcd_bus_arb.sv
// Two-requester round-robin arbiter driving an 8080-style parallel LCD write bus.
// Each grant becomes one SETUP / WR_LO / WR_HI strobe sequence with programmable phase lengths.
module lcd_bus_arb #(
  parameter int unsigned DW = 24,
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_rs,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_rs,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [TW-1:0] cfg_lo,
  input  logic [TW-1:0] cfg_hi,
  output logic          lcd_cs,
  output logic          lcd_rs,
  output logic          lcd_wr,
  output logic [DW-1:0] lcd_data,
  output logic          busy,
  output logic          last_gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] cnt;
  logic [TW-1:0] txn_lo;
  logic [TW-1:0] txn_hi;

  logic          gnt_any;
  logic          gnt_idx;
  logic          gnt_rs;
  logic [DW-1:0] gnt_data;

  // Grant selection: only in IDLE and out of reset; contention goes to the requester not served last.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = 1'b0;
    gnt_rs     = req0_rs;
    gnt_data   = req0_data;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst && (state == IDLE) && (req0_valid || req1_valid)) begin
      gnt_any = 1'b1;
      if (req0_valid && req1_valid) begin
        gnt_idx = ~last_gnt;
      end else begin
        gnt_idx = req1_valid;
      end
    end
    if (gnt_idx) begin
      gnt_rs   = req1_rs;
      gnt_data = req1_data;
    end
    req0_ready = gnt_any & ~gnt_idx;
    req1_ready = gnt_any & gnt_idx;
  end

  // lcd_rs/lcd_data double as the transaction payload register; timing fields are snapshotted at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      txn_lo   <= '0;
      txn_hi   <= '0;
      lcd_cs   <= 1'b1;
      lcd_wr   <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      busy     <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state    <= SETUP;
            txn_lo   <= cfg_lo;
            txn_hi   <= cfg_hi;
            lcd_rs   <= gnt_rs;
            lcd_data <= gnt_data;
            lcd_cs   <= 1'b0;
            lcd_wr   <= 1'b1;
            busy     <= 1'b1;
            last_gnt <= gnt_idx;
          end
        end
        SETUP: begin
          state  <= WR_LO;
          lcd_wr <= 1'b0;
          cnt    <= txn_lo;
        end
        WR_LO: begin
          if (cnt == '0) begin
            state  <= WR_HI;
            lcd_wr <= 1'b1;
            cnt    <= txn_hi;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        WR_HI: begin
          if (cnt == '0) begin
            state  <= IDLE;
            lcd_cs <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          lcd_cs <= 1'b1;
          lcd_wr <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_bus_arb.md
LCD_BUS_ARB -- requirements
Module: lcd_bus_arb

Interface
REQ-001 The block SHALL have parameter DW, default 24, giving the LCD data bus width in bits.
REQ-002 The block SHALL have parameter TW, default 4, giving the width of the strobe timing fields.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port req0_valid, input, 1 bit: requester 0 has a transaction pending.
REQ-006 Port req0_rs, input, 1 bit: requester 0 register-select (0 = command, 1 = data).
REQ-007 Port req0_data, input, DW bits: requester 0 write data.
REQ-008 Port req0_ready, output, 1 bit: requester 0 transaction accepted this cycle.
REQ-009 Ports req1_valid, req1_rs, req1_data and req1_ready SHALL mirror REQ-005 to REQ-008 for requester 1.
REQ-010 Port cfg_lo, input, TW bits: write-strobe low time minus 1, in clk cycles.
REQ-011 Port cfg_hi, input, TW bits: write-strobe high (recovery) time minus 1, in clk cycles.
REQ-012 Port lcd_cs, output, 1 bit: LCD chip select, active-low.
REQ-013 Port lcd_rs, output, 1 bit: LCD register select.
REQ-014 Port lcd_wr, output, 1 bit: LCD write strobe, active-low; data is latched by the panel on its rising edge.
REQ-015 Port lcd_data, output, DW bits: LCD data bus.
REQ-016 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 Port last_gnt, output, 1 bit: index of the most recently granted requester.

Function
REQ-018 The FSM SHALL have four states: IDLE, SETUP, WR_LO and WR_HI.
REQ-019 In IDLE with at least one valid request, the block SHALL grant one requester and assert its ready combinationally in that same cycle.
REQ-020 The grant SHALL be registered into a transaction register, which captures rs, data, cfg_lo and cfg_hi, and the FSM SHALL move to SETUP.
REQ-021 At most one ready SHALL be high in any cycle, and ready SHALL only be high in IDLE.
REQ-022 Arbitration SHALL be round-robin: with both requesters valid, the grant goes to the requester that was not last_gnt.
REQ-023 With a single requester valid, that requester SHALL be granted regardless of last_gnt.
REQ-024 last_gnt SHALL update on every grant.
REQ-025 SETUP SHALL last exactly 1 cycle with lcd_cs=0, lcd_wr=1 and rs/data driven from the transaction register.
REQ-026 WR_LO SHALL last cfg_lo+1 cycles with lcd_wr=0, using a down-counter loaded on entry.
REQ-027 WR_HI SHALL last cfg_hi+1 cycles with lcd_wr=1 and lcd_cs=0, then the FSM SHALL return to IDLE.
REQ-028 lcd_rs and lcd_data SHALL hold stable from SETUP through the end of WR_HI.
REQ-029 In IDLE, lcd_cs and lcd_wr SHALL be 1, and lcd_rs and lcd_data SHALL hold their last driven values.
REQ-030 The total transaction time from the accept cycle N to the next possible accept SHALL be 1+(cfg_lo+1)+(cfg_hi+1)+1 cycles; the next accept is at cycle N+cfg_lo+cfg_hi+4.
REQ-031 A change on cfg_lo or cfg_hi during a transaction SHALL have no effect until the next accept.
REQ-032 With cfg fields at their maximum value (2^TW-1), each strobe phase SHALL last 2^TW cycles and the counter SHALL not wrap.
REQ-033 A valid request deasserted before being granted SHALL be dropped without any LCD activity.
REQ-034 All outputs SHALL be driven from registers, except req0_ready and req1_ready.

Reset
REQ-035 rst=0 SHALL force, asynchronously, state=IDLE, lcd_cs=1, lcd_wr=1, lcd_rs=0, lcd_data=0, busy=0, counter=0 and last_gnt=1, so that requester 0 wins the first contention.
REQ-036 While rst=0, req0_ready and req1_ready SHALL be 0.
REQ-037 rst asserted mid-transaction SHALL abort the transaction with no further strobe edges, and the aborted request SHALL not be retried.
REQ-038 After rst deasserts, the first grant SHALL occur no earlier than the first rising clk edge at which rst is sampled high.

Verification
REQ-039 Scenario: reset, then req0_valid=1, rs=1, data=0x00F800, cfg_lo=0, cfg_hi=0 -> req0_ready high 1 cycle; lcd_cs low for 3 cycles; lcd_wr low for exactly 1 cycle; lcd_data=0x00F800 with lcd_rs=1 throughout.
REQ-040 Scenario: both requesters valid continuously from reset -> grant order 0,1,0,1; each accept 4 cycles apart at cfg 0/0.
REQ-041 Scenario: cfg_lo=3, cfg_hi=2 -> lcd_wr low for 4 cycles, then high for 3 cycles with cs low; busy high for 8 cycles.
REQ-042 Scenario: cfg_lo=15, cfg_hi=15 (TW=4) -> lcd_wr low for 16 cycles, recovery 16 cycles, no counter wrap.
REQ-043 Scenario: cfg_lo changed from 3 to 0 during WR_LO -> current pulse stays 4 cycles; next transaction uses 1 cycle.
REQ-044 Scenario: rst pulsed low during WR_LO -> lcd_wr and lcd_cs go to 1 asynchronously; the FSM is in IDLE and the next grant goes to req0.
